// File: rtl/eth_frame_pkg.sv
`default_nettype none
//==============================================================================
// Module  : eth_frame_pkg
// Brief   : Shared types and field widths for the Ethernet frame writer.
// Revision: 1.0 - initial release
//==============================================================================
package eth_frame_pkg;

    localparam int ETH_MAC_W  = 48;
    localparam int ETH_TYPE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eth_frame_writer.sv
`default_nettype none
//==============================================================================
// Module  : eth_frame_writer
// Brief   : Latches a header and payload descriptor, emits the header, then
//           streams len words from a sync-read memory with AXIS backpressure.
// Revision: 1.0 - initial release
//==============================================================================
module eth_frame_writer
    import eth_frame_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     len,
    input  logic [ETH_MAC_W-1:0]  dest_mac,
    input  logic [ETH_MAC_W-1:0]  src_mac,
    input  logic [ETH_TYPE_W-1:0] eth_type,
    input  logic                  tx_busy,
    output logic                  ready,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  s_eth_hdr_valid,
    input  logic                  s_eth_hdr_ready,
    output logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
    output logic [ETH_MAC_W-1:0]  s_eth_src_mac,
    output logic [ETH_TYPE_W-1:0] s_eth_type,
    output logic [DATA_W-1:0]     s_eth_payload_axis_tdata,
    output logic                  s_eth_payload_axis_tvalid,
    input  logic                  s_eth_payload_axis_tready,
    output logic                  s_eth_payload_axis_tlast,
    output logic                  s_eth_payload_axis_tuser
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_idx;
    logic [ADDR_W-1:0]       r_base;
    logic [ADDR_W-1:0]       r_len;
    logic [ETH_MAC_W-1:0]    r_dest_mac;
    logic [ETH_MAC_W-1:0]    r_src_mac;
    logic [ETH_TYPE_W-1:0]   r_eth_type;
    logic                    r_done;
    logic                    r_hdr_valid;
    logic                    r_tvalid;

    logic                    w_accept;
    logic                    w_fire;
    logic                    w_last;
    logic [ADDR_W-1:0]       w_fire_ext;
    logic [ADDR_W-1:0]       w_raddr;
    logic [DATA_W-1:0]       w_tdata;

    assign ready      = (r_state == IDLE) && !tx_busy;
    assign w_accept   = start && ready;
    assign w_fire     = r_tvalid && s_eth_payload_axis_tready;
    assign w_fire_ext = {{(ADDR_W-1){1'b0}}, w_fire};

    // Read address runs one word ahead only when a beat is consumed, so a
    // stalled beat keeps the same memory word on tdata.
    always @(*) begin
        w_raddr = '0;
        w_tdata = '0;
        w_last  = 1'b0;
        case (r_state)
            HDR: begin
                w_raddr = r_base;
            end
            DATA: begin
                w_tdata = mem_rdata;
                w_last  = (r_idx == (r_len - c_one));
                w_raddr = r_base + r_idx + w_fire_ext;
            end
            default: begin
                w_raddr = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_dest_mac  <= '0;
            r_src_mac   <= '0;
            r_eth_type  <= '0;
            r_done      <= 1'b0;
            r_hdr_valid <= 1'b0;
            r_tvalid    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (len != '0) begin
                            r_base      <= base_addr;
                            r_len       <= len;
                            r_dest_mac  <= dest_mac;
                            r_src_mac   <= src_mac;
                            r_eth_type  <= eth_type;
                            r_idx       <= '0;
                            r_hdr_valid <= 1'b1;
                            r_state     <= HDR;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                HDR: begin
                    if (s_eth_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_tvalid    <= 1'b1;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        r_idx <= r_idx + c_one;
                        if (w_last) begin
                            r_tvalid <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done                      = r_done;
    assign mem_raddr                 = w_raddr;
    assign s_eth_hdr_valid           = r_hdr_valid;
    assign s_eth_dest_mac            = r_dest_mac;
    assign s_eth_src_mac             = r_src_mac;
    assign s_eth_type                = r_eth_type;
    assign s_eth_payload_axis_tdata  = w_tdata;
    assign s_eth_payload_axis_tvalid = r_tvalid;
    assign s_eth_payload_axis_tlast  = w_last;
    assign s_eth_payload_axis_tuser  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_writer.sv
`default_nettype none
//==============================================================================
// Module  : tb_eth_frame_writer
// Brief   : Self-checking bench for eth_frame_writer against a frame-level model.
// Revision: 1.0 - initial release
//==============================================================================
module tb_eth_frame_writer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len;
    logic [47:0]       dest_mac;
    logic [47:0]       src_mac;
    logic [15:0]       eth_type;
    logic              tx_busy;
    logic              ready;
    logic              done;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              s_eth_hdr_valid;
    logic              s_eth_hdr_ready;
    logic [47:0]       s_eth_dest_mac;
    logic [47:0]       s_eth_src_mac;
    logic [15:0]       s_eth_type;
    logic [DATA_W-1:0] s_eth_payload_axis_tdata;
    logic              s_eth_payload_axis_tvalid;
    logic              s_eth_payload_axis_tready;
    logic              s_eth_payload_axis_tlast;
    logic              s_eth_payload_axis_tuser;

    eth_frame_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .base_addr                 (base_addr),
        .len                       (len),
        .dest_mac                  (dest_mac),
        .src_mac                   (src_mac),
        .eth_type                  (eth_type),
        .tx_busy                   (tx_busy),
        .ready                     (ready),
        .done                      (done),
        .mem_raddr                 (mem_raddr),
        .mem_rdata                 (mem_rdata),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser)
    );

    always #5 clk = ~clk;

    // Payload memory: synchronous read, re-read every cycle.
    logic [DATA_W-1:0] mem [256];
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  flen;
        logic [15:0] etype;
        int          tr_mode;   // 0: always ready, 1: 1,0,0 pattern, 2: random
        int          hdr_stall;
        bit          inj;       // pulse start while streaming
        int          exp_lat;   // expected done cycle after accept, -1 = unchecked
    } vec_t;

    task automatic run_frame(input logic [7:0] base, input logic [7:0] flen,
                             input logic [15:0] etype, input int tr_mode,
                             input int hdr_stall, input bit inj, input int exp_lat);
        logic [63:0] rnd;
        logic [47:0] dm, sm, p_dm, p_sm;
        logic [15:0] p_et;
        logic [7:0]  exp_q[$];
        logic [7:0]  got_d[$];
        logic        got_l[$];
        logic [7:0]  p_td;
        logic        p_hv, p_hr, p_tv, p_tr, p_tl, hr, tr;
        int          c, hs_cnt, hv_first, done_cyc, stall_left, tv_before;
        bit          injected;

        rnd = {$urandom(), $urandom()};
        dm  = rnd[47:0];
        rnd = {$urandom(), $urandom()};
        sm  = rnd[47:0];
        for (int i = 0; i < int'(flen); i++)
            exp_q.push_back(mem[(int'(base) + i) % 256]);

        @(negedge clk);
        chk("ready_before_start", 64'(ready), 64'(1));
        chk("done_single_cycle", 64'(done), 64'(0));
        start = 1'b1; base_addr = base; len = flen;
        dest_mac = dm; src_mac = sm; eth_type = etype;
        hs_cnt = 0; hv_first = -1; done_cyc = -1; stall_left = hdr_stall;
        tv_before = 0; injected = 1'b0;
        p_hv = 1'b0; p_hr = 1'b0; p_tv = 1'b0; p_tr = 1'b0; p_tl = 1'b0;
        p_td = '0; p_dm = '0; p_sm = '0; p_et = '0;
        c = 0;
        while (done_cyc < 0 && c < 3000) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c == 1) begin
                base_addr = 8'($urandom()); len = 8'($urandom());
                dest_mac = 48'({$urandom(), $urandom()});
                src_mac = 48'({$urandom(), $urandom()}); eth_type = 16'($urandom());
            end
            if (s_eth_hdr_valid && hv_first < 0) hv_first = c;
            if (p_hv && !p_hr) begin
                chk("hdr_valid_held", 64'(s_eth_hdr_valid), 64'(1));
                chk("hdr_dest_stable", 64'(s_eth_dest_mac), 64'(p_dm));
                chk("hdr_src_stable", 64'(s_eth_src_mac), 64'(p_sm));
                chk("hdr_type_stable", 64'(s_eth_type), 64'(p_et));
            end
            if (p_tv && !p_tr) begin
                chk("tvalid_held", 64'(s_eth_payload_axis_tvalid), 64'(1));
                chk("tdata_stable", 64'(s_eth_payload_axis_tdata), 64'(p_td));
                chk("tlast_stable", 64'(s_eth_payload_axis_tlast), 64'(p_tl));
            end
            if (s_eth_payload_axis_tvalid && hs_cnt == 0) tv_before++;
            if (flen == 8'd0) chk("len0_raddr_quiet", 64'(mem_raddr), 64'(0));
            if (done) done_cyc = c;

            if (s_eth_hdr_valid) begin
                if (stall_left > 0) begin
                    stall_left--;
                    hr = 1'b0;
                end else begin
                    hr = 1'b1;
                end
            end else begin
                hr = 1'($urandom_range(0, 1));
            end
            case (tr_mode)
                0:       tr = 1'b1;
                1:       tr = (c % 3 == 2);
                default: tr = 1'($urandom_range(0, 1));
            endcase
            if (inj && !injected && s_eth_payload_axis_tvalid) begin
                start = 1'b1; base_addr = 8'($urandom()); len = 8'd3;
                injected = 1'b1;
            end
            tx_busy = (tr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_eth_hdr_ready = hr;
            s_eth_payload_axis_tready = tr;

            if (s_eth_hdr_valid && hr) begin
                hs_cnt++;
                chk("hdr_dest_mac", 64'(s_eth_dest_mac), 64'(dm));
                chk("hdr_src_mac", 64'(s_eth_src_mac), 64'(sm));
                chk("hdr_eth_type", 64'(s_eth_type), 64'(etype));
            end
            if (s_eth_payload_axis_tvalid && tr) begin
                got_d.push_back(s_eth_payload_axis_tdata);
                got_l.push_back(s_eth_payload_axis_tlast);
            end
            p_hv = s_eth_hdr_valid; p_hr = hr;
            p_tv = s_eth_payload_axis_tvalid; p_tr = tr;
            p_td = s_eth_payload_axis_tdata; p_tl = s_eth_payload_axis_tlast;
            p_dm = s_eth_dest_mac; p_sm = s_eth_src_mac; p_et = s_eth_type;
        end
        tx_busy = 1'b0; start = 1'b0;
        s_eth_hdr_ready = 1'b0; s_eth_payload_axis_tready = 1'b0;

        chk("done_seen", 64'(done_cyc >= 0), 64'(1));
        if (flen != 8'd0) chk("hdr_valid_rise_T+1", 64'(hv_first), 64'(1));
        else              chk("no_hdr_len0", 64'(hv_first < 0), 64'(1));
        chk("hdr_handshakes", 64'(hs_cnt), 64'((flen != 8'd0) ? 1 : 0));
        chk("tvalid_before_hdr", 64'(tv_before), 64'(0));
        chk("beat_count", 64'(got_d.size()), 64'(flen));
        for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
            chk("beat_data", 64'(got_d[i]), 64'(exp_q[i]));
            chk("beat_tlast", 64'(got_l[i]), 64'(i == int'(flen) - 1));
        end
        if (exp_lat >= 0) chk("done_latency", 64'(done_cyc), 64'(exp_lat));
    endtask

    vec_t vecs[8];
    int   fires;
    int   cyc;

    initial begin
        vecs[0] = '{8'h10, 8'd4,   16'h0800, 0, 0, 1'b0, 6};
        vecs[1] = '{8'h20, 8'd6,   16'h86DD, 1, 0, 1'b0, -1};
        vecs[2] = '{8'h30, 8'd3,   16'h0806, 0, 5, 1'b0, -1};
        vecs[3] = '{8'h40, 8'd1,   16'h0800, 0, 0, 1'b0, 3};
        vecs[4] = '{8'h50, 8'd0,   16'h0800, 0, 0, 1'b0, 1};
        vecs[5] = '{8'hFE, 8'd4,   16'h0800, 0, 0, 1'b0, 6};
        vecs[6] = '{8'h60, 8'd8,   16'h0800, 0, 0, 1'b1, 10};
        vecs[7] = '{8'h05, 8'd255, 16'h1234, 2, 1, 1'b0, -1};

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'(8'hA0 + i);

        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        dest_mac = '0; src_mac = '0; eth_type = '0; tx_busy = 1'b0;
        s_eth_hdr_ready = 1'b0; s_eth_payload_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hdr_valid", 64'(s_eth_hdr_valid), 64'(0));
        chk("rst_tvalid", 64'(s_eth_payload_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(s_eth_payload_axis_tlast), 64'(0));
        chk("rst_raddr", 64'(mem_raddr), 64'(0));
        chk("rst_dest_mac", 64'(s_eth_dest_mac), 64'(0));
        chk("rst_tuser", 64'(s_eth_payload_axis_tuser), 64'(0));
        rst = 1'b0;

        // Consecutive calls start the next frame the cycle after done.
        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].base, vecs[v].flen, vecs[v].etype, vecs[v].tr_mode,
                      vecs[v].hdr_stall, vecs[v].inj, vecs[v].exp_lat);

        // start while the framer is busy must be ignored
        @(negedge clk);
        tx_busy = 1'b1; start = 1'b1; base_addr = 8'h33; len = 8'd5;
        #1;
        chk("busy_ready_low", 64'(ready), 64'(0));
        repeat (3) begin
            @(negedge clk);
            chk("busy_no_hdr", 64'(s_eth_hdr_valid), 64'(0));
            chk("busy_no_done", 64'(done), 64'(0));
        end
        tx_busy = 1'b0; start = 1'b0;

        // reset after the second of eight beats
        @(negedge clk);
        start = 1'b1; base_addr = 8'h80; len = 8'd8;
        s_eth_hdr_ready = 1'b1; s_eth_payload_axis_tready = 1'b1;
        fires = 0; cyc = 0;
        while (fires < 2 && cyc < 50) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (s_eth_payload_axis_tvalid) begin
                chk("rst_seq_beat", 64'(s_eth_payload_axis_tdata), 64'(mem[8'h80 + fires]));
                fires++;
            end
        end
        chk("rst_seq_beats_reached", 64'(fires), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", 64'(s_eth_payload_axis_tvalid), 64'(0));
        chk("midrst_hdr_valid", 64'(s_eth_hdr_valid), 64'(0));
        chk("midrst_tlast", 64'(s_eth_payload_axis_tlast), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_raddr", 64'(mem_raddr), 64'(0));
        chk("midrst_ready", 64'(ready), 64'(1));
        rst = 1'b0; s_eth_hdr_ready = 1'b0; s_eth_payload_axis_tready = 1'b0;
        run_frame(8'h90, 8'd5, 16'h0800, 0, 0, 1'b0, 7);

        // randomized frames against the model
        for (int k = 0; k < 12; k++)
            run_frame(8'($urandom()), 8'($urandom_range(0, 40)), 16'($urandom()), 2,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);

        @(negedge clk);
        chk("final_done_low", 64'(done), 64'(0));
        chk("final_ready", 64'(ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
